// File: rtl/zet_front_fifo_if.sv
// Front-end FIFO bus between the prefetch stage (writer) and the instruction decoder (reader).
// master drives writes/pops/flush; slave is the FIFO itself.
interface zet_front_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic                  flush;
  logic                  wr_fifo;
  logic [15:0]           fifo_dat_i;
  logic [15:0]           fifo_ip_i;
  logic                  fifo_odd_i;
  logic                  fifo_full;
  logic [7:0]            byte_o;
  logic [15:0]           byte_ip_o;
  logic                  byte_vld_o;
  logic                  byte_rd_i;
  logic [DEPTH_LOG2:0]   level_o;

  modport master (
    output flush, wr_fifo, fifo_dat_i, fifo_ip_i, fifo_odd_i, byte_rd_i,
    input  fifo_full, byte_o, byte_ip_o, byte_vld_o, level_o
  );

  modport slave (
    input  flush, wr_fifo, fifo_dat_i, fifo_ip_i, fifo_odd_i, byte_rd_i,
    output fifo_full, byte_o, byte_ip_o, byte_vld_o, level_o
  );
endinterface

// File: rtl/zet_front_fifo.sv
// Prefetch word FIFO that presents queued 16-bit instruction words to the decoder one byte at a time.
// Odd-address words carry only their upper byte.
module zet_front_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input logic             clk,
  input logic             rst,
  zet_front_fifo_if.slave bus
);
  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  // Entry storage is never cleared; count/pointers decide what is live.
  logic [15:0] dat_q [Depth];
  logic [15:0] ip_q  [Depth];
  logic        odd_q [Depth];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  h_q, h_d;

  logic        full, vld, sel;
  logic        wr_en, pop, pop_word;
  logic [15:0] head_dat, head_ip;
  logic        head_odd;

  always_comb begin
    full     = (count_q == DepthCnt);
    vld      = (count_q != '0);
    head_dat = dat_q[rd_ptr_q];
    head_ip  = ip_q[rd_ptr_q];
    head_odd = odd_q[rd_ptr_q];
    sel      = h_q | head_odd;
    wr_en    = bus.wr_fifo & ~full & ~bus.flush;
    pop      = bus.byte_rd_i & vld;
    pop_word = pop & sel;
  end

  always_comb begin
    bus.fifo_full  = full;
    bus.byte_vld_o = vld;
    bus.level_o    = count_q;
    bus.byte_o     = 8'h00;
    bus.byte_ip_o  = 16'h0000;
    if (vld) begin
      bus.byte_o    = sel ? head_dat[15:8] : head_dat[7:0];
      bus.byte_ip_o = head_ip + 16'(h_q);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    h_d      = h_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      h_d      = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_word) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      // Low half consumed: stay on this word; high half consumed: word is gone.
      if (pop) h_d = ~sel;
      unique case ({wr_en, pop_word})
        2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      h_q      <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      h_q      <= h_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      dat_q[wr_ptr_q] <= bus.fifo_dat_i;
      ip_q[wr_ptr_q]  <= bus.fifo_ip_i;
      odd_q[wr_ptr_q] <= bus.fifo_odd_i;
    end
  end
endmodule

// File: tb/tb_zet_front_fifo.sv
// Bench for zet_front_fifo: directed scenarios then random traffic against a word-queue model
// that expands each word into the bytes it contributes.
module tb_zet_front_fifo;
  localparam int unsigned DL2   = 3;
  localparam int unsigned DEPTH = 2 ** DL2;

  logic clk;
  logic rst;
  zet_front_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  zet_front_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] dat;
    logic [15:0] ip;
    logic        odd;
  } word_t;

  word_t q[$];
  int    consumed;  // bytes already taken from the head word
  int    vectors;
  int    miscompares;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bytes a word supplies: odd -> just the high byte at ip; even -> low at ip, high at ip+1.
  function automatic int n_bytes(input word_t w);
    return w.odd ? 1 : 2;
  endfunction

  task automatic exp_head(output logic [7:0] b, output logic [15:0] ip);
    word_t w;
    b  = 8'h00;
    ip = 16'h0000;
    if (q.size() != 0) begin
      w = q[0];
      if (w.odd) begin
        b  = w.dat[15:8];
        ip = w.ip;
      end else begin
        b  = (consumed == 0) ? w.dat[7:0] : w.dat[15:8];
        ip = w.ip + 16'(consumed);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0]  eb;
    logic [15:0] eip;
    exp_head(eb, eip);
    chk({tag, "_level"}, 16'(bus.level_o), 16'(q.size()));
    chk({tag, "_vld"},   16'(bus.byte_vld_o), 16'(q.size() != 0));
    chk({tag, "_full"},  16'(bus.fifo_full), 16'(q.size() == DEPTH));
    chk({tag, "_byte"},  16'(bus.byte_o), 16'(eb));
    chk({tag, "_ip"},    bus.byte_ip_o, eip);
  endtask

  task automatic model_edge(input logic wr, input word_t w, input logic rd, input logic fl);
    bit was_full;
    if (fl) begin
      q.delete();
      consumed = 0;
      return;
    end
    was_full = (q.size() == DEPTH);
    if (rd && q.size() != 0) begin
      consumed++;
      if (consumed == n_bytes(q[0])) begin
        void'(q.pop_front());
        consumed = 0;
      end
    end
    if (wr && !was_full) q.push_back(w);
  endtask

  task automatic step(input string tag, input logic wr, input logic [15:0] dat,
                      input logic [15:0] ip, input logic odd, input logic rd, input logic fl);
    word_t w;
    w = '{dat: dat, ip: ip, odd: odd};
    bus.wr_fifo    = wr;
    bus.fifo_dat_i = dat;
    bus.fifo_ip_i  = ip;
    bus.fifo_odd_i = odd;
    bus.byte_rd_i  = rd;
    bus.flush      = fl;
    @(posedge clk);
    model_edge(wr, w, rd, fl);
    #1;
    bus.wr_fifo   = 1'b0;
    bus.byte_rd_i = 1'b0;
    bus.flush     = 1'b0;
    check_all(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    consumed    = 0;
    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.wr_fifo    = 1'b0;
    bus.fifo_dat_i = '0;
    bus.fifo_ip_i  = '0;
    bus.fifo_odd_i = 1'b0;
    bus.byte_rd_i  = 1'b0;
    #1;
    check_all("reset");
    #12 rst = 1'b1;
    @(posedge clk);
    #1;

    // Even word, two pops
    step("w31", 1'b1, 16'hB8A1, 16'h0100, 1'b0, 1'b0, 1'b0);
    chk("r31_b0", 16'(bus.byte_o), 16'h00A1);
    chk("r31_ip0", bus.byte_ip_o, 16'h0100);
    step("p31a", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("r31_b1", 16'(bus.byte_o), 16'h00B8);
    chk("r31_ip1", bus.byte_ip_o, 16'h0101);
    step("p31b", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("r31_empty", 16'(bus.byte_vld_o), 16'h0);

    // Odd word: single byte
    step("w32", 1'b1, 16'h3C00, 16'h0101, 1'b1, 1'b0, 1'b0);
    chk("r32_b", 16'(bus.byte_o), 16'h003C);
    step("p32", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("r32_lvl", 16'(bus.level_o), 16'h0);

    // Fill, overfill, drain one word, refill
    for (int i = 0; i < 8; i++)
      step("fill", 1'b1, 16'(16'h1100 + i), 16'(16'h0200 + 2 * i), 1'b0, 1'b0, 1'b0);
    chk("r33_full", 16'(bus.fifo_full), 16'h1);
    step("over", 1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    chk("r33_lvl8", 16'(bus.level_o), 16'h8);
    step("pop2", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    step("refill", 1'b1, 16'h7766, 16'h0300, 1'b0, 1'b0, 1'b0);
    chk("r33_relvl", 16'(bus.level_o), 16'h8);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);

    // IP wrap
    step("w34", 1'b1, 16'h5544, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step("p34", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("r34_wrap", bus.byte_ip_o, 16'h0000);
    step("p34b", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Flush beats simultaneous write and pop
    for (int i = 0; i < 3; i++) step("w35", 1'b1, 16'(16'hA0A0 + i), 16'(i), 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, 16'h1234, 16'h4000, 1'b0, 1'b1, 1'b1);
    chk("r35_lvl", 16'(bus.level_o), 16'h0);

    // Asynchronous reset mid-stream with h=1
    for (int i = 0; i < 5; i++) step("w36", 1'b1, 16'(16'hC0C0 + i), 16'(16'h0500 + i), 1'b0, 1'b0, 1'b0);
    step("h1", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    q.delete();
    consumed = 0;
    #1;
    check_all("arst");
    #2 rst = 1'b1;
    step("postrst", 1'b1, 16'h9988, 16'h0700, 1'b0, 1'b0, 1'b0);
    chk("r36_b", 16'(bus.byte_o), 16'h0088);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd", 1'($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/zet_front_fifo.md
ZET_FRONT_FIFO -- requirements
Module: zet_front_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 3, log2 of the number of 16-bit word entries (DEPTH = 2**DEPTH_LOG2).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous clear of all queued contents.
REQ-005 wr_fifo  input  1  write strobe from the prefetch stage.
REQ-006 fifo_dat_i  input  16  instruction word; [7:0] is the lower address byte.
REQ-007 fifo_ip_i  input  16  IP of the first valid byte of fifo_dat_i.
REQ-008 fifo_odd_i  input  1  1 = only [15:8] valid (odd-address fetch).
REQ-009 fifo_full  output  1  1 = no free entry; writes ignored.
REQ-010 byte_o  output  8  head instruction byte.
REQ-011 byte_ip_o  output  16  IP of byte_o.
REQ-012 byte_vld_o  output  1  byte_o/byte_ip_o valid.
REQ-013 byte_rd_i  input  1  decoder consumes the head byte this cycle.
REQ-014 level_o  output  DEPTH_LOG2+1  number of occupied word entries.

Function
REQ-015 Storage: DEPTH entries of {dat[15:0], ip[15:0], odd}, circular, with write pointer, read pointer (DEPTH_LOG2 bits, natural wrap DEPTH-1 -> 0), and word count.
REQ-016 Write accepted when wr_fifo=1 and fifo_full=0: entry stored at write pointer; pointer +1; write while full: no state change, no error.
REQ-017 fifo_full SHALL equal (count == DEPTH), derived from the registered count; a same-cycle pop does not enable a write while full.
REQ-018 byte_vld_o SHALL equal (count != 0); level_o SHALL equal count.
REQ-019 Half-select register h (1 bit) addresses the byte within the head entry; selected half sel = h | head.odd.
REQ-020 byte_o = sel ? head.dat[15:8] : head.dat[7:0]; byte_ip_o = head.ip + h, 16-bit, wrapping 0xFFFF -> 0x0000.
REQ-021 While empty, byte_o SHALL be 8'h00 and byte_ip_o 16'h0000.
REQ-022 Pop: byte_rd_i=1 with byte_vld_o=1 and sel=0 -> h<=1, word retained.
REQ-023 Pop: byte_rd_i=1 with byte_vld_o=1 and sel=1 -> entry freed, read pointer +1, h<=0.
REQ-024 byte_rd_i while byte_vld_o=0: ignored.
REQ-025 Same-cycle accepted write and word-freeing pop: count unchanged, both pointers advance.
REQ-026 Read latency: a word written in cycle N SHALL be visible at byte_o in cycle N+1 when the FIFO was empty (no bypass).
REQ-027 flush=1: count, both pointers and h cleared next edge; flush has priority over simultaneous write and pop (both discarded).
REQ-028 Entry data is not cleared by flush or reset; only pointers/count/h are state that matters.

Reset
REQ-029 rst low SHALL immediately (asynchronously) set count=0, pointers=0, h=0; hence fifo_full=0, byte_vld_o=0, byte_o=8'h00, byte_ip_o=16'h0000, level_o=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; after rst returns high the first accepted write behaves as into an empty FIFO.

Verification
REQ-031 Write {dat=16'hB8A1, ip=16'h0100, odd=0}, then pop twice -> byte_o/byte_ip_o = A1/0100, then B8/0101; byte_vld_o=0 after.
REQ-032 Write {dat=16'h3C00, ip=16'h0101, odd=1} -> byte_o=3C, byte_ip_o=0101; one pop frees word, level_o 1 -> 0.
REQ-033 DEPTH=8: 8 writes with no pop -> fifo_full=1, level_o=8; 9th write ignored; two pops then write -> accepted, level_o=8 again.
REQ-034 Write {ip=16'hFFFF, odd=0} -> second byte_ip_o=16'h0000 (wrap).
REQ-035 level_o=3, assert flush with wr_fifo=1 and byte_rd_i=1 -> next cycle level_o=0, byte_vld_o=0, fifo_full=0.
REQ-036 rst low mid-stream with level_o=5 and h=1 -> outputs at reset values immediately, without a clock edge; first post-reset write appears at byte_o one cycle later.
